lib_accdump: RTL and testbench

//  Accumulate-and-dump stage consuming lib_adsb results in the TD-SCDMA demodulator.

---
 rtl/lib_accdump_if.sv | 29 ++
 rtl/lib_accdump.sv | 116 +++++++++++
 tb/tb_lib_accdump.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/lib_accdump_if.sv
// Accumulate-and-dump port bundle: sample input side plus dumped symbol output side.
// Latency: none, wires only.
// Backpressure: none; the producer qualifies samples with d_vld and the consumer must take every q_vld pulse.
interface lib_accdump_if #(
  parameter int N = 16,
  parameter int L = 4,
  parameter int M = 16
) ();
  logic         clr;
  logic [L-1:0] len;
  logic         d_vld;
  logic [N:0]   d_in;
  logic         busy;
  logic         q_vld;
  logic [M-1:0] q;
  logic         q_sat;

  // Producer side: drives samples and block control, observes results.
  modport master (
    output clr, len, d_vld, d_in,
    input  busy, q_vld, q, q_sat
  );

  // Accumulator side.
  modport slave (
    input  clr, len, d_vld, d_in,
    output busy, q_vld, q, q_sat
  );
endinterface

// File: rtl/lib_accdump.sv
// Sums a programmable-length block of signed despread chips, dumps one rounded, saturated symbol.
// Latency: q_vld pulses one cycle after the edge that accepts the block's last sample.
// Backpressure: none; every d_vld sample is consumed, clr aborts the block in progress.
module lib_accdump #(
  parameter int N  = 16,
  parameter int L  = 4,
  parameter int SH = 4,
  parameter int M  = 16
) (
  input  logic          clk,
  input  logic          rst,
  lib_accdump_if.slave  bus
);
  // Full-precision accumulator width: 2^L samples of N+1 bits never overflow it.
  localparam int A = N + 1 + L;
  localparam logic [L:0]        EFF_MAX = (L+1)'(1 << L);
  // Half-LSB rounding constant; zero when no shift is applied.
  localparam logic signed [A:0] RND_ADD = (A+1)'((1 << SH) >> 1);
  localparam logic signed [A:0] QMAX    = (A+1)'((1 << (M - 1)) - 1);
  localparam logic signed [A:0] QMIN    = ~QMAX;

  typedef enum logic {IDLE, ACC} state_t;

  state_t              state_q, state_d;
  logic signed [A-1:0] acc_q, acc_d;
  logic [L-1:0]        cnt_q, cnt_d;
  logic [L-1:0]        len_q, len_d;
  logic [M-1:0]        q_q, q_d;
  logic                q_vld_q, q_vld_d;
  logic                q_sat_q, q_sat_d;

  logic [L-1:0]        len_sel;
  logic [L:0]          eff_len;
  logic [L:0]          cnt_inc;
  logic                last;
  logic signed [A-1:0] sum;
  logic signed [A:0]   rnd_pre;
  logic signed [A:0]   rnd;

  // Datapath: block length in force, last-sample detect, running sum and rounded value.
  always_comb begin
    len_sel = (state_q == IDLE) ? bus.len : len_q;
    eff_len = (len_sel == '0) ? EFF_MAX : {1'b0, len_sel};
    cnt_inc = {1'b0, cnt_q} + 1'b1;
    last    = (cnt_inc == eff_len);
    sum     = ((state_q == IDLE) ? '0 : acc_q) + {{L{bus.d_in[N]}}, bus.d_in};
    rnd_pre = $signed({sum[A-1], sum}) + RND_ADD;
    rnd     = rnd_pre >>> SH;
  end

  // Next-state: abort on clr, accumulate on d_vld, dump and saturate on the last sample.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    q_d     = q_q;
    q_sat_d = q_sat_q;
    q_vld_d = 1'b0;
    if (bus.clr) begin
      acc_d   = '0;
      cnt_d   = '0;
      state_d = IDLE;
    end else if (bus.d_vld) begin
      if (state_q == IDLE) begin
        len_d = bus.len;
      end
      if (last) begin
        acc_d   = '0;
        cnt_d   = '0;
        state_d = IDLE;
        q_vld_d = 1'b1;
        if (rnd > QMAX) begin
          q_d     = QMAX[M-1:0];
          q_sat_d = 1'b1;
        end else if (rnd < QMIN) begin
          q_d     = QMIN[M-1:0];
          q_sat_d = 1'b1;
        end else begin
          q_d     = rnd[M-1:0];
          q_sat_d = 1'b0;
        end
      end else begin
        acc_d   = sum;
        cnt_d   = cnt_q + 1'b1;
        state_d = ACC;
      end
    end
  end

  // State and output registers; reset discards any partial block.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      len_q   <= '0;
      q_q     <= '0;
      q_vld_q <= 1'b0;
      q_sat_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      q_q     <= q_d;
      q_vld_q <= q_vld_d;
      q_sat_q <= q_sat_d;
    end
  end

  assign bus.busy  = (state_q == ACC);
  assign bus.q_vld = q_vld_q;
  assign bus.q     = q_q;
  assign bus.q_sat = q_sat_q;
endmodule

// File: tb/tb_lib_accdump.sv
// Bench for lib_accdump: directed blocks checked cycle by cycle against an integer block model.
// Latency: model result expected on the cycle after the accepting edge.
// Backpressure: none; the bench drives one sample per cycle or leaves gaps.
module tb_lib_accdump;
  localparam int N  = 16;
  localparam int L  = 4;
  localparam int SH = 4;
  localparam int M  = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;

  lib_accdump_if #(.N(N), .L(L), .M(M)) bus ();

  lib_accdump #(.N(N), .L(L), .SH(SH), .M(M)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  // Block model: plain integer sum over the block, then round and clamp.
  int m_acc = 0, m_cnt = 0, m_len = 0, m_q = 0;
  bit m_qsat = 0, m_qvld = 0;

  always @(posedge clk or posedge rst) begin
    int r;
    if (rst) begin
      m_acc = 0; m_cnt = 0; m_len = 0; m_q = 0; m_qsat = 0; m_qvld = 0;
    end else begin
      m_qvld = 0;
      if (bus.clr) begin
        m_acc = 0; m_cnt = 0;
      end else if (bus.d_vld) begin
        if (m_cnt == 0) begin
          m_len = (bus.len == 0) ? (1 << L) : int'(bus.len);
          m_acc = 0;
        end
        m_acc += int'($signed(bus.d_in));
        m_cnt++;
        if (m_cnt == m_len) begin
          r = (m_acc + ((1 << SH) >> 1)) >>> SH;
          if (r > 32767)       begin m_q = 32767;  m_qsat = 1; end
          else if (r < -32768) begin m_q = -32768; m_qsat = 1; end
          else                 begin m_q = r;      m_qsat = 0; end
          m_qvld = 1;
          m_acc = 0; m_cnt = 0;
        end
      end
    end
  end

  // Per-cycle compare, plus a log of dumped symbols from both DUT and model.
  int got_q[$], got_s[$], mod_q[$], mod_s[$];

  always @(negedge clk) begin
    chk("busy",  int'(bus.busy),  int'(m_cnt != 0));
    chk("q_vld", int'(bus.q_vld), int'(m_qvld));
    chk("q",     int'($signed(bus.q)), m_q);
    chk("q_sat", int'(bus.q_sat), int'(m_qsat));
    if (bus.q_vld) begin got_q.push_back(int'($signed(bus.q))); got_s.push_back(int'(bus.q_sat)); end
    if (m_qvld)    begin mod_q.push_back(m_q); mod_s.push_back(int'(m_qsat)); end
  end

  task automatic send(input int d);
    bus.d_vld = 1'b1;
    bus.d_in  = (N+1)'(d);
    @(negedge clk);
    bus.d_vld = 1'b0;
  endtask

  // Check the k-th dumped symbol (from the start of the run) of both DUT and model.
  task automatic expect_sym(input string nm, input int k, input int q, input int s);
    chk({nm, "_dut_q"},   (got_q.size() > k) ? got_q[k] : 99999, q);
    chk({nm, "_dut_sat"}, (got_s.size() > k) ? got_s[k] : 9, s);
    chk({nm, "_mdl_q"},   (mod_q.size() > k) ? mod_q[k] : 99999, q);
    chk({nm, "_mdl_sat"}, (mod_s.size() > k) ? mod_s[k] : 9, s);
  endtask

  initial begin
    bus.clr = 1'b0; bus.len = '0; bus.d_vld = 1'b0; bus.d_in = '0;
    #1 rst = 1'b1;
    #1;
    chk("rst_q",     int'(bus.q),     0);
    chk("rst_q_vld", int'(bus.q_vld), 0);
    chk("rst_busy",  int'(bus.busy),  0);
    chk("rst_q_sat", int'(bus.q_sat), 0);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);

    // 1: 1000 + 8 >>> 4 = 63
    bus.len = 4'd4;
    send(100); send(200); send(300); send(400);
    repeat (3) @(negedge clk); #1;
    expect_sym("t1", 0, 63, 0);
    @(negedge clk);

    // 2: full-length blocks clamp at both rails
    bus.len = 4'd0;
    for (int i = 0; i < 16; i++) send(65535);
    for (int i = 0; i < 16; i++) send(-65536);
    repeat (3) @(negedge clk); #1;
    expect_sym("t2p", 1, 32767, 1);
    expect_sym("t2n", 2, -32768, 1);
    @(negedge clk);

    // 3: single-sample blocks, round half toward +inf
    bus.len = 4'd1;
    send(-9); send(-8); send(7); send(8);
    repeat (3) @(negedge clk); #1;
    expect_sym("t3a", 3, -1, 0);
    expect_sym("t3b", 4, 0, 0);
    expect_sym("t3c", 5, 0, 0);
    expect_sym("t3d", 6, 1, 0);
    @(negedge clk);

    // 4: gaps inside a block keep it open; 48 + 8 >>> 4 = 3
    bus.len = 4'd3;
    send(16); #1 chk("t4_busy_gap1", int'(bus.busy), 1);
    repeat (2) @(negedge clk);
    send(16); #1 chk("t4_busy_gap2", int'(bus.busy), 1);
    repeat (2) @(negedge clk);
    bus.len = 4'd1;  // ignored mid-block
    send(16);
    repeat (3) @(negedge clk); #1;
    expect_sym("t4", 7, 3, 0);
    @(negedge clk);

    // 5: clr aborts the partial block; only the following block dumps
    bus.len = 4'd4;
    send(99); send(99);
    bus.clr = 1'b1; bus.d_vld = 1'b1; bus.d_in = (N+1)'(99);
    @(negedge clk);
    bus.clr = 1'b0; bus.d_vld = 1'b0;
    #1 chk("t5_busy_after_clr", int'(bus.busy), 0);
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(32);
    repeat (3) @(negedge clk); #1;
    chk("t5_pulses", got_q.size(), 9);
    expect_sym("t5", 8, 8, 0);
    @(negedge clk);

    // 6: reset mid-block clears everything at once; 64 + 8 >>> 4 = 4
    send(16); send(16);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_q",     int'(bus.q),     0);
    chk("t6_rst_q_vld", int'(bus.q_vld), 0);
    chk("t6_rst_busy",  int'(bus.busy),  0);
    chk("t6_rst_q_sat", int'(bus.q_sat), 0);
    @(negedge clk); #2 rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) send(16);
    repeat (3) @(negedge clk); #1;
    chk("t6_pulses", got_q.size(), 10);
    expect_sym("t6", 9, 4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
